// File: rtl/digit_overlay_pkg.sv
// Shared types and default sizing for the on-screen digit overlay mux.
// Blink support is compiled in only when BLINK_ON_CHANGE_EN is defined.
package digit_overlay_pkg;

  localparam int COORD_W          = 11;
  localparam int DIGIT_W          = 4;
  localparam int DEF_CH           = 4;
  localparam int DEF_BLINK_FRAMES = 32;
  localparam int DEF_BLINK_HALF   = 4;
  localparam int CNT_W            = 8;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [DIGIT_W-1:0] digit_t;

endpackage

// File: rtl/digit_overlay_mux_blink_tracker.sv
// Per-channel change detector and blink frame countdown.
// Only built when BLINK_ON_CHANGE_EN is defined.
`ifdef BLINK_ON_CHANGE_EN
module blink_tracker
  import digit_overlay_pkg::*;
#(
  parameter int NW           = DIGIT_W,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          primed,
  input  logic          sof,
  input  logic [NW-1:0] num,
  output logic          blinking
);

  logic [CNT_W-1:0] cnt;
  logic [NW-1:0]    num_prev;

  // A reload beats a same-cycle frame decrement.
  always_ff @(posedge clk) begin
    num_prev <= num;
    if (!resetN)
      cnt <= '0;
    else if (primed && (num != num_prev))
      cnt <= CNT_W'(BLINK_FRAMES);
    else if (sof && (cnt != '0))
      cnt <= cnt - 1'b1;
  end

  assign blinking = (cnt != '0);

endmodule
`endif

// File: rtl/digit_overlay_mux.sv
// Registered fixed-priority mux of digit sprite requests.
// BLINK_ON_CHANGE_EN adds blink-after-change masking per channel.
module digit_overlay_mux
  import digit_overlay_pkg::*;
#(
  parameter int CH           = DEF_CH,
  parameter int XW           = COORD_W,
  parameter int NW           = DIGIT_W,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES,
  parameter int BLINK_HALF   = DEF_BLINK_HALF,
  localparam int SW          = $clog2(CH)
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             startOfFrame,
  input  logic [CH-1:0]    seq_i,
  input  logic [CH*XW-1:0] x_i,
  input  logic [CH*XW-1:0] y_i,
  input  logic [CH*NW-1:0] num_i,
  output logic             seq_o,
  output logic [XW-1:0]    x_o,
  output logic [XW-1:0]    y_o,
  output logic [NW-1:0]    num_o,
  output logic [SW-1:0]    sel_o
);

  logic [CH-1:0] mask;
  logic [CH-1:0] eligible;
  logic          hit;
  logic [SW-1:0] idx;

`ifdef BLINK_ON_CHANGE_EN
  localparam int FW = $clog2(BLINK_HALF) + 1;

  logic [FW-1:0] fcnt;
  logic          primed;
  logic [CH-1:0] blinking;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      fcnt   <= '0;
      primed <= 1'b0;
    end else begin
      primed <= 1'b1;
      if (startOfFrame)
        fcnt <= fcnt + 1'b1;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_trk
    blink_tracker #(
      .NW          (NW),
      .BLINK_FRAMES(BLINK_FRAMES)
    ) u_trk (
      .clk     (clk),
      .resetN  (resetN),
      .primed  (primed),
      .sof     (startOfFrame),
      .num     (num_i[k*NW +: NW]),
      .blinking(blinking[k])
    );
  end

  // Counter MSB is the hidden half of the blink period.
  assign mask = blinking & {CH{fcnt[FW-1]}};
`else
  logic unused_sof;
  assign unused_sof = startOfFrame;
  assign mask       = '0;
`endif

  assign eligible = seq_i & ~mask;

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = CH - 1; k >= 0; k--) begin
      if (eligible[k]) begin
        hit = 1'b1;
        idx = SW'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      seq_o <= 1'b0;
      x_o   <= '0;
      y_o   <= '0;
      num_o <= '0;
      sel_o <= '0;
    end else begin
      seq_o <= hit;
      x_o   <= hit ? x_i[idx*XW +: XW] : '0;
      y_o   <= hit ? y_i[idx*XW +: XW] : '0;
      num_o <= hit ? num_i[idx*NW +: NW] : '0;
      sel_o <= hit ? idx : '0;
    end
  end

endmodule
